// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_unit_pkg;

   localparam int unsigned IQ_DEPTH_DEF  = 8;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0;
   localparam int unsigned INST_W        = 32;
   localparam int unsigned ADDR_W        = 32;

   typedef enum logic [1:0] {
      FETCH_IDLE    = 2'd0,
      FETCH_WAIT    = 2'd1,
      FETCH_DISCARD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } iq_entry_t;

endpackage

// File: rtl/fetch_unit_inst_queue.sv
// Show-ahead in-order instruction queue of {pc, inst}; head and valid are registered.
module fetch_unit_inst_queue
   import fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = IQ_DEPTH_DEF,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = PW + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_en,
   input  logic            i_push,
   input  logic            i_pop,
   input  logic            i_flush,
   input  iq_entry_t       i_entry,
   output logic            o_valid,
   output iq_entry_t       o_head,
   output logic [CW-1:0]   o_count_nxt_c
);

   iq_entry_t         r_mem [DEPTH];
   logic [PW-1:0]     r_rd;
   logic [PW-1:0]     r_wr;
   logic [CW-1:0]     r_count;
   logic              r_valid;
   iq_entry_t         r_head;

   logic              w_pop;
   logic [PW-1:0]     w_rd_nxt;
   logic [PW-1:0]     w_wr_nxt;
   logic [CW-1:0]     w_count_nxt;
   iq_entry_t         w_head_nxt;

   // Next pointers/count; the head is bypassed from the write port when it lands on an empty queue.
   always_comb begin
      w_pop       = i_pop && (r_count != '0);
      w_rd_nxt    = r_rd;
      w_wr_nxt    = r_wr;
      w_count_nxt = r_count;
      w_head_nxt  = r_head;
      if (i_flush) begin
         w_rd_nxt    = '0;
         w_wr_nxt    = '0;
         w_count_nxt = '0;
      end else begin
         if (w_pop)  w_rd_nxt = r_rd + PW'(1);
         if (i_push) w_wr_nxt = r_wr + PW'(1);
         w_count_nxt = r_count + CW'(i_push) - CW'(w_pop);
         if (w_count_nxt != '0) begin
            if (i_push && (r_wr == w_rd_nxt)) w_head_nxt = i_entry;
            else                              w_head_nxt = r_mem[w_rd_nxt];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         r_valid <= 1'b0;
         r_head  <= '0;
      end else if (i_en) begin
         r_rd    <= w_rd_nxt;
         r_wr    <= w_wr_nxt;
         r_count <= w_count_nxt;
         r_valid <= (w_count_nxt != '0);
         r_head  <= w_head_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (i_en && i_push && !i_flush) r_mem[r_wr] <= i_entry;
   end

   assign o_valid       = r_valid;
   assign o_head        = r_head;
   assign o_count_nxt_c = i_en ? w_count_nxt : r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding memory FSM, redirect handling, and the IF->Issue queue.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned IQ_DEPTH = IQ_DEPTH_DEF,
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req_ready,
   input  logic              mem_resp_valid,
   input  logic [INST_W-1:0] mem_resp_inst,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst_to_issue,
   output logic [ADDR_W-1:0] pc_to_issue,
   input  logic              issue_stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
);

   localparam int unsigned CW = $clog2(IQ_DEPTH) + 1;

   fetch_state_e      r_state;
   logic [ADDR_W-1:0] r_pc;
   logic              r_mem_req_valid;
   logic [ADDR_W-1:0] r_mem_req_addr;

   fetch_state_e      w_state_nxt;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic              w_fire;
   logic              w_push;
   logic              w_pop;
   logic              w_flush;
   logic              w_req_nxt;
   logic [CW-1:0]     w_count_nxt;
   iq_entry_t         w_entry;
   iq_entry_t         w_head;
   logic              w_inst_valid;

   assign w_fire  = r_mem_req_valid && mem_req_ready;
   assign w_entry = '{pc: r_pc, inst: mem_resp_inst};

   // Redirect wins over every other event; a response racing it is dropped.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_push      = 1'b0;
      w_pop       = w_inst_valid && !issue_stall;
      w_flush     = 1'b0;
      if (redirect_valid) begin
         w_flush  = 1'b1;
         w_pop    = 1'b0;
         w_pc_nxt = redirect_pc & ~32'h3;
         case (r_state)
            FETCH_IDLE:    w_state_nxt = w_fire ? FETCH_DISCARD : FETCH_IDLE;
            FETCH_WAIT:    w_state_nxt = mem_resp_valid ? FETCH_IDLE : FETCH_DISCARD;
            FETCH_DISCARD: w_state_nxt = mem_resp_valid ? FETCH_IDLE : FETCH_DISCARD;
            default:       w_state_nxt = FETCH_IDLE;
         endcase
      end else begin
         case (r_state)
            FETCH_IDLE: begin
               if (w_fire) w_state_nxt = FETCH_WAIT;
            end
            FETCH_WAIT: begin
               if (mem_resp_valid) begin
                  w_push      = 1'b1;
                  w_pc_nxt    = r_pc + 32'd4;
                  w_state_nxt = FETCH_IDLE;
               end
            end
            FETCH_DISCARD: begin
               if (mem_resp_valid) w_state_nxt = FETCH_IDLE;
            end
            default: w_state_nxt = FETCH_IDLE;
         endcase
      end
   end

   // Request only with a free slot counted after this cycle's push/pop.
   assign w_req_nxt = (w_state_nxt == FETCH_IDLE) && (w_count_nxt < CW'(IQ_DEPTH));

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state         <= FETCH_IDLE;
         r_pc            <= RESET_PC;
         r_mem_req_valid <= 1'b0;
         r_mem_req_addr  <= '0;
      end else if (rdy) begin
         r_state         <= w_state_nxt;
         r_pc            <= w_pc_nxt;
         r_mem_req_valid <= w_req_nxt;
         r_mem_req_addr  <= w_pc_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && rdy && (r_state == FETCH_IDLE)) begin
         assert (!mem_resp_valid)
            else $error("fetch_unit: mem_resp_valid with no request outstanding");
      end
   end

   fetch_unit_inst_queue #(.DEPTH(IQ_DEPTH)) u_iq (
      .clk           (clk),
      .rst           (rst),
      .i_en          (rdy),
      .i_push        (w_push),
      .i_pop         (w_pop),
      .i_flush       (w_flush),
      .i_entry       (w_entry),
      .o_valid       (w_inst_valid),
      .o_head        (w_head),
      .o_count_nxt_c (w_count_nxt)
   );

   assign mem_req_valid = r_mem_req_valid;
   assign mem_req_addr  = r_mem_req_addr;
   assign inst_valid    = w_inst_valid;
   assign inst_to_issue = w_head.inst;
   assign pc_to_issue   = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fill/drain, simultaneous push/pop, redirects and rdy freeze.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_inst;
   logic        inst_valid;
   logic [31:0] inst_to_issue;
   logic [31:0] pc_to_issue;
   logic        issue_stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_inst  (mem_resp_inst),
      .inst_valid     (inst_valid),
      .inst_to_issue  (inst_to_issue),
      .pc_to_issue    (pc_to_issue),
      .issue_stall    (issue_stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
         else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
   endtask

   initial begin
      logic [31:0] pc;

      rst = 1'b0; rdy = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      mem_resp_inst = '0; issue_stall = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      tick(); tick();
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst_to_issue, 32'h0);
      chk("rst_pc", pc_to_issue, 32'h0);

      // First fetch after reset release
      rst = 1'b1;
      tick();
      chk("first_req_valid", 32'(mem_req_valid), 32'd1);
      chk("first_req_addr", mem_req_addr, 32'h0);
      mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
      chk("wait_req_low", 32'(mem_req_valid), 32'd0);
      tick();
      mem_resp_valid = 1'b1; mem_resp_inst = 32'h0000_0013; tick(); mem_resp_valid = 1'b0;
      chk("first_inst_valid", 32'(inst_valid), 32'd1);
      chk("first_pc", pc_to_issue, 32'h0);
      chk("first_inst", inst_to_issue, 32'h0000_0013);
      chk("second_req_valid", 32'(mem_req_valid), 32'd1);
      chk("second_req_addr", mem_req_addr, 32'h4);

      // Fill the queue under stall
      for (int k = 1; k < 8; k++) begin
         pc = 32'(4 * k);
         chk("fill_req_valid", 32'(mem_req_valid), 32'd1);
         chk("fill_req_addr", mem_req_addr, pc);
         mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
         mem_resp_valid = 1'b1; mem_resp_inst = 32'h100 + pc; tick(); mem_resp_valid = 1'b0;
      end
      chk("full_req_stop", 32'(mem_req_valid), 32'd0);
      mem_req_ready = 1'b1; tick(); tick(); mem_req_ready = 1'b0;
      chk("full_req_still_stop", 32'(mem_req_valid), 32'd0);
      chk("full_head_pc", pc_to_issue, 32'h0);

      // One pop frees a slot; request resumes at 0x20
      issue_stall = 1'b0; tick(); issue_stall = 1'b1;
      chk("pop1_head_pc", pc_to_issue, 32'h4);
      chk("pop1_head_inst", inst_to_issue, 32'h104);
      chk("pop1_req_valid", 32'(mem_req_valid), 32'd1);
      chk("pop1_req_addr", mem_req_addr, 32'h20);

      // Push and pop in the same cycle
      mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_inst = 32'h120; issue_stall = 1'b0;
      tick();
      mem_resp_valid = 1'b0; issue_stall = 1'b1;
      chk("pp_head_pc", pc_to_issue, 32'h8);
      chk("pp_head_inst", inst_to_issue, 32'h108);
      chk("pp_req_valid", 32'(mem_req_valid), 32'd1);
      chk("pp_req_addr", mem_req_addr, 32'h24);

      // Drain in order 0x8..0x20
      issue_stall = 1'b0;
      for (int k = 0; k < 7; k++) begin
         pc = 32'(8 + 4 * k);
         chk("drain_valid", 32'(inst_valid), 32'd1);
         chk("drain_pc", pc_to_issue, pc);
         chk("drain_inst", inst_to_issue, 32'h100 + pc);
         tick();
      end
      chk("drain_empty", 32'(inst_valid), 32'd0);
      issue_stall = 1'b1;

      // Redirect while WAIT; late response discarded
      mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_inst = 32'h124; tick(); mem_resp_valid = 1'b0;
      chk("pre_redir_valid", 32'(inst_valid), 32'd1);
      chk("pre_redir_pc", pc_to_issue, 32'h24);
      mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h100; tick(); redirect_valid = 1'b0;
      chk("redir_flush", 32'(inst_valid), 32'd0);
      chk("redir_discard_req", 32'(mem_req_valid), 32'd0);
      tick(); tick();
      mem_resp_valid = 1'b1; mem_resp_inst = 32'hDEAD_BEEF; tick(); mem_resp_valid = 1'b0;
      chk("discard_dropped", 32'(inst_valid), 32'd0);
      chk("discard_req_valid", 32'(mem_req_valid), 32'd1);
      chk("discard_req_addr", mem_req_addr, 32'h100);
      mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_inst = 32'h1111_1111; tick(); mem_resp_valid = 1'b0;
      chk("target_valid", 32'(inst_valid), 32'd1);
      chk("target_pc", pc_to_issue, 32'h100);
      chk("target_inst", inst_to_issue, 32'h1111_1111);
      chk("target_next_addr", mem_req_addr, 32'h104);

      // Redirect coincident with response in WAIT; low bits of target cleared
      mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_inst = 32'hBAD0_BAD0;
      redirect_valid = 1'b1; redirect_pc = 32'h203;
      tick();
      mem_resp_valid = 1'b0; redirect_valid = 1'b0;
      chk("same_cyc_flush", 32'(inst_valid), 32'd0);
      chk("same_cyc_req_valid", 32'(mem_req_valid), 32'd1);
      chk("same_cyc_req_addr", mem_req_addr, 32'h200);

      // Redirect coincident with request acceptance in IDLE
      mem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
      tick();
      mem_req_ready = 1'b0; redirect_valid = 1'b0;
      chk("idle_redir_discard", 32'(mem_req_valid), 32'd0);
      mem_resp_valid = 1'b1; mem_resp_inst = 32'h55; tick(); mem_resp_valid = 1'b0;
      chk("idle_redir_dropped", 32'(inst_valid), 32'd0);
      chk("idle_redir_req_valid", 32'(mem_req_valid), 32'd1);
      chk("idle_redir_req_addr", mem_req_addr, 32'h300);
      mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_inst = 32'h0003_00AA; tick(); mem_resp_valid = 1'b0;
      chk("idle_redir_pc", pc_to_issue, 32'h300);

      // rdy=0 freezes everything while WAIT
      mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
      chk("freeze_pre_req", 32'(mem_req_valid), 32'd0);
      rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         mem_resp_valid = k[0];
         mem_resp_inst  = 32'hFFFF_0000;
         redirect_valid = ~k[0];
         redirect_pc    = 32'h500;
         tick();
         chk("freeze_req", 32'(mem_req_valid), 32'd0);
         chk("freeze_valid", 32'(inst_valid), 32'd1);
         chk("freeze_pc", pc_to_issue, 32'h300);
      end
      mem_resp_valid = 1'b0; redirect_valid = 1'b0; rdy = 1'b1;
      tick();
      chk("thaw_still_wait", 32'(mem_req_valid), 32'd0);
      chk("thaw_head_pc", pc_to_issue, 32'h300);
      mem_resp_valid = 1'b1; mem_resp_inst = 32'h0003_04BB; tick(); mem_resp_valid = 1'b0;
      chk("thaw_req_valid", 32'(mem_req_valid), 32'd1);
      chk("thaw_req_addr", mem_req_addr, 32'h308);
      chk("thaw_head_hold", pc_to_issue, 32'h300);
      issue_stall = 1'b0; tick(); issue_stall = 1'b1;
      chk("thaw_pop_valid", 32'(inst_valid), 32'd1);
      chk("thaw_pop_pc", pc_to_issue, 32'h304);
      chk("thaw_pop_inst", inst_to_issue, 32'h0003_04BB);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
